// File: rtl/mem_load_unit_pkg.sv
// rtl/mem_load_unit_pkg.sv - load opcodes and alignment helpers shared by mem_load_unit
// LOAD_LWLR_EN adds LWL/LWR to the set of recognised load opcodes.
package mem_load_unit_pkg;

  typedef logic [5:0] loadOpT;

  localparam loadOpT EXE_LB  = 6'b100000;
  localparam loadOpT EXE_LH  = 6'b100001;
  localparam loadOpT EXE_LWL = 6'b100010;
  localparam loadOpT EXE_LW  = 6'b100011;
  localparam loadOpT EXE_LBU = 6'b100100;
  localparam loadOpT EXE_LHU = 6'b100101;
  localparam loadOpT EXE_LWR = 6'b100110;

  function automatic logic isLoadOp(input loadOpT op);
    case (op)
      EXE_LB, EXE_LBU, EXE_LH, EXE_LHU, EXE_LW: isLoadOp = 1'b1;
`ifdef LOAD_LWLR_EN
      EXE_LWL, EXE_LWR:                         isLoadOp = 1'b1;
`else
`endif
      default:                                  isLoadOp = 1'b0;
    endcase
  endfunction

  // LWL/LWR are unaligned by design and never fault
  function automatic logic isMisaligned(input loadOpT op, input logic [1:0] off);
    case (op)
      EXE_LH, EXE_LHU: isMisaligned = off[0];
      EXE_LW:          isMisaligned = |off;
      default:         isMisaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_extract.sv
// rtl/mem_load_unit_extract.sv - load_extract: selects and extends load data by opcode and byte offset
// LOAD_LWLR_EN enables the LWL/LWR merge with the old rt value.
module load_extract
  import mem_load_unit_pkg::*;
(
  input  loadOpT      op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

`ifdef LOAD_LWLR_EN
  logic [31:0] lwlResult;
  logic [31:0] lwrResult;

  always_comb begin
    case (off)
      2'd0:    lwlResult = {rdata[7:0],  rt[23:0]};
      2'd1:    lwlResult = {rdata[15:0], rt[15:0]};
      2'd2:    lwlResult = {rdata[23:0], rt[7:0]};
      default: lwlResult = rdata;
    endcase
    case (off)
      2'd0:    lwrResult = rdata;
      2'd1:    lwrResult = {rt[31:24], rdata[31:8]};
      2'd2:    lwrResult = {rt[31:16], rdata[31:16]};
      default: lwrResult = {rt[31:8],  rdata[31:24]};
    endcase
  end
`else
  logic unusedRt;
  assign unusedRt = ^rt;
`endif

  always_comb begin
    byteSel = rdata[{off, 3'b000} +: 8];
    halfSel = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      EXE_LB:  result = {{24{byteSel[7]}}, byteSel};
      EXE_LBU: result = {24'b0, byteSel};
      EXE_LH:  result = {{16{halfSel[15]}}, halfSel};
      EXE_LHU: result = {16'b0, halfSel};
`ifdef LOAD_LWLR_EN
      EXE_LWL: result = lwlResult;
      EXE_LWR: result = lwrResult;
`else
`endif
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// rtl/mem_load_unit.sv - M-stage load unit: issues word reads, stalls until data, registers W-stage result
// Optional LWL/LWR support is built when LOAD_LWLR_EN is defined.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req_m,
  input  logic [5:0]  load_op_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] rt_m,
  input  logic        flush_except,
  output logic        data_req,
  output logic [31:0] data_addr,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        load_stall,
  output logic        load_adel,
  output logic        load_buserr,
  output logic [31:0] result_w,
  output logic        result_vld_w
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int            TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  logic [2:0]    state;
  logic [2:0]    nextState;
  loadOpT        latchedOp;
  logic [1:0]    latchedOff;
  logic [31:0]   latchedRt;
  logic [29:0]   latchedAddr;
  logic [TW-1:0] timer;
  logic [31:0]   extracted;
  logic          loadHit;
  logic          adel;
  logic          issue;
  logic          timeoutHit;

  // The M-stage instruction is only looked at while idle; in DONE it is the load just completed
  assign loadHit    = (state == S_IDLE) && load_req_m && isLoadOp(load_op_m);
  assign adel       = loadHit && isMisaligned(load_op_m, addr_m[1:0]);
  assign issue      = loadHit && !adel && !flush_except;
  assign timeoutHit = (TIMEOUT != 0) && (timer == TLAST);

  assign load_adel    = adel;
  assign data_req     = issue || (state == S_REQ);
  assign data_addr    = (state == S_REQ) ? {latchedAddr, 2'b00} : {addr_m[31:2], 2'b00};
  assign load_stall   = (loadHit && !adel) || (state == S_REQ) || (state == S_WAIT) || (state == S_DRAIN);
  assign load_buserr  = (state == S_WAIT) && !flush_except && !data_data_ok && timeoutHit;
  assign result_vld_w = (state == S_DONE);

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (issue) nextState = S_REQ;
      S_REQ: begin
        if (data_addr_ok) begin
          if (flush_except) nextState = data_data_ok ? S_IDLE : S_DRAIN;
          else              nextState = data_data_ok ? S_DONE : S_WAIT;
        end else if (flush_except) begin
          nextState = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_except)      nextState = data_data_ok ? S_IDLE : S_DRAIN;
        else if (data_data_ok) nextState = S_DONE;
        else if (timeoutHit)   nextState = S_DRAIN;
      end
      S_DRAIN: if (data_data_ok) nextState = S_IDLE;
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  load_extract uExtract (
    .op     (latchedOp),
    .off    (latchedOff),
    .rdata  (data_rdata),
    .rt     (latchedRt),
    .result (extracted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      result_w    <= '0;
      latchedOp   <= '0;
      latchedOff  <= '0;
      latchedRt   <= '0;
      latchedAddr <= '0;
    end else begin
      state <= nextState;
      if (issue) begin
        latchedOp   <= load_op_m;
        latchedOff  <= addr_m[1:0];
        latchedRt   <= rt_m;
        latchedAddr <= addr_m[31:2];
      end
      if (state != S_WAIT)  timer <= '0;
      else if (timer != '1) timer <= timer + 1'b1;
      if (nextState == S_DONE) result_w <= extracted;
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// tb/tb_mem_load_unit.sv - self-checking bench for mem_load_unit (TIMEOUT=4)
// LOAD_LWLR_EN selects the LWL/LWR expectations.
module tb_mem_load_unit;
  import mem_load_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req_m;
  logic [5:0]  load_op_m;
  logic [31:0] addr_m;
  logic [31:0] rt_m;
  logic        flush_except;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        load_stall;
  logic        load_adel;
  logic        load_buserr;
  logic [31:0] result_w;
  logic        result_vld_w;

  int total = 0;
  int bad = 0;
  logic [31:0] lastResult = '0;

  always #5 clk = ~clk;

  mem_load_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .load_req_m(load_req_m), .load_op_m(load_op_m), .addr_m(addr_m),
    .rt_m(rt_m), .flush_except(flush_except), .data_req(data_req), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .load_stall(load_stall), .load_adel(load_adel), .load_buserr(load_buserr),
    .result_w(result_w), .result_vld_w(result_vld_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelIsLoad(logic [5:0] op);
    bit r;
    r = (op == EXE_LB) || (op == EXE_LBU) || (op == EXE_LH) || (op == EXE_LHU) || (op == EXE_LW);
`ifdef LOAD_LWLR_EN
    r = r || (op == EXE_LWL) || (op == EXE_LWR);
`else
`endif
    return r;
  endfunction

  function automatic bit modelAdel(logic [5:0] op, logic [31:0] addr);
    return (((op == EXE_LH) || (op == EXE_LHU)) && (addr % 2 != 0)) || ((op == EXE_LW) && (addr % 4 != 0));
  endfunction

  function automatic logic [31:0] modelResult(logic [5:0] op, logic [31:0] addr, logic [31:0] rdata, logic [31:0] rt);
    int o;
    int sh;
    logic [31:0] b;
    logic [31:0] h;
    o = int'(addr % 4);
    b = (rdata >> (8 * o)) & 32'hFF;
    h = (rdata >> (16 * (o / 2))) & 32'hFFFF;
    if (op == EXE_LB)  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
    if (op == EXE_LBU) return b;
    if (op == EXE_LH)  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
    if (op == EXE_LHU) return h;
    if (op == EXE_LWL) begin
      sh = 8 * (3 - o);
      return (rdata << sh) | (rt & ((32'h1 << sh) - 32'h1));
    end
    if (op == EXE_LWR) begin
      sh = 8 * o;
      return (rdata >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
    end
    return rdata;
  endfunction

  // Drives one load with addr_ok aDly cycles after issue and data_ok dDly cycles after that
  task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [31:0] rdata, input int aDly, input int dDly,
                          output int stallCycles, output bit addrStable, output int vldCycles,
                          output logic [31:0] res, output bit reqInDone, output bit finished);
    bit done;
    done = 0; stallCycles = 0; addrStable = 1; vldCycles = 0; res = '0; reqInDone = 0;
    load_req_m = 1; load_op_m = op; addr_m = addr; rt_m = rt;
    for (int c = 0; c < 40 && !done; c++) begin
      data_addr_ok = (c == aDly);
      data_data_ok = (c == aDly + dDly);
      data_rdata   = (c == aDly + dDly) ? rdata : $urandom;
      if (c > 0) rt_m = $urandom;
      #1;
      if (load_stall) stallCycles++;
      if (data_req && data_addr !== {addr[31:2], 2'b00}) addrStable = 0;
      if (result_vld_w) begin
        vldCycles++; res = result_w; reqInDone = data_req; done = 1;
      end
      step();
    end
    load_req_m = 0; data_addr_ok = 0; data_data_ok = 0;
    #1;
    if (result_vld_w) vldCycles++;
    if (load_stall) stallCycles++;
    finished = done;
    step();
  endtask

  task automatic test_reset();
    load_req_m = 0; load_op_m = '0; addr_m = '0; rt_m = '0; flush_except = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
    rst = 1;
    step(); step();
    total++; if (data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", data_req); end
    total++; if (load_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", load_stall); end
    total++; if (load_buserr !== 1'b0) begin bad++; $display("FAIL reset_buserr got=%b exp=0", load_buserr); end
    total++; if (result_w !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_w); end
    total++; if (result_vld_w !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", result_vld_w); end
    total++; if (load_adel !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b exp=0", load_adel); end
    rst = 0;
    step();
    lastResult = '0;
  endtask

  task automatic test_lb();
    int st; int vc; bit ast; bit rq; bit fin; logic [31:0] res;
    run_load(EXE_LB, 32'h1003, 32'h0, 32'h80FF_0102, 1, 0, st, ast, vc, res, rq, fin);
    total++; if (res !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h exp=ffffff80", res); end
    total++; if (vc !== 1) begin bad++; $display("FAIL lb_vld_cycles got=%0d exp=1", vc); end
    total++; if (st !== 2) begin bad++; $display("FAIL lb_min_latency_stall got=%0d exp=2", st); end
    total++; if (rq !== 1'b0) begin bad++; $display("FAIL lb_req_in_done got=%b exp=0", rq); end
    run_load(EXE_LBU, 32'h1003, 32'h0, 32'h80FF_0102, 1, 0, st, ast, vc, res, rq, fin);
    total++; if (res !== 32'h0000_0080) begin bad++; $display("FAIL lbu_result got=%h exp=00000080", res); end
    lastResult = res;
  endtask

  task automatic test_adel();
    int adelCnt; int reqCnt; int stallCnt;
    adelCnt = 0; reqCnt = 0; stallCnt = 0;
    load_req_m = 1; load_op_m = EXE_LH; addr_m = 32'h1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (load_adel) adelCnt++;
      if (data_req) reqCnt++;
      if (load_stall) stallCnt++;
      step();
    end
    load_op_m = EXE_LW; addr_m = 32'h1002;
    #1;
    if (load_adel) adelCnt++;
    if (data_req) reqCnt++;
    if (load_stall) stallCnt++;
    step();
    load_req_m = 0;
    step();
    total++; if (adelCnt !== 4) begin bad++; $display("FAIL adel_count got=%0d exp=4", adelCnt); end
    total++; if (reqCnt !== 0) begin bad++; $display("FAIL adel_req got=%0d exp=0", reqCnt); end
    total++; if (stallCnt !== 0) begin bad++; $display("FAIL adel_stall got=%0d exp=0", stallCnt); end
  endtask

  task automatic test_lw_delayed();
    int st; int vc; bit ast; bit rq; bit fin; logic [31:0] res; logic [31:0] rd;
    rd = $urandom;
    run_load(EXE_LW, 32'h2000, 32'h0, rd, 3, 2, st, ast, vc, res, rq, fin);
    total++; if (st !== 6) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=6", st); end
    total++; if (ast !== 1'b1) begin bad++; $display("FAIL lw_addr_stable got=%b exp=1", ast); end
    total++; if (res !== rd) begin bad++; $display("FAIL lw_result got=%h exp=%h", res, rd); end
    total++; if (vc !== 1) begin bad++; $display("FAIL lw_vld_cycles got=%0d exp=1", vc); end
    lastResult = rd;
  endtask

  task automatic test_flush();
    int drainStall; int stallAfter; int vldSeen;
    drainStall = 0; stallAfter = 0; vldSeen = 0;
    load_req_m = 1; load_op_m = EXE_LW; addr_m = 32'h3000; rt_m = '0;
    for (int c = 0; c < 9; c++) begin
      data_addr_ok = (c == 1); flush_except = (c == 2); data_data_ok = (c == 5);
      data_rdata = (c == 5) ? 32'h1234_5678 : $urandom;
      if (c == 2) load_req_m = 0;
      #1;
      if (c >= 3 && c <= 5 && load_stall) drainStall++;
      if (c >= 6 && load_stall) stallAfter++;
      if (result_vld_w) vldSeen++;
      step();
    end
    flush_except = 0; data_addr_ok = 0; data_data_ok = 0;
    total++; if (drainStall !== 3) begin bad++; $display("FAIL flush_drain_stall got=%0d exp=3", drainStall); end
    total++; if (stallAfter !== 0) begin bad++; $display("FAIL flush_idle_stall got=%0d exp=0", stallAfter); end
    total++; if (vldSeen !== 0) begin bad++; $display("FAIL flush_vld got=%0d exp=0", vldSeen); end
    total++; if (result_w !== lastResult) begin bad++; $display("FAIL flush_result_kept got=%h exp=%h", result_w, lastResult); end
  endtask

  task automatic test_flush_with_data();
    int stallAfter; int vldSeen;
    stallAfter = 0; vldSeen = 0;
    load_req_m = 1; load_op_m = EXE_LW; addr_m = 32'h3100;
    for (int c = 0; c < 6; c++) begin
      data_addr_ok = (c == 1); flush_except = (c == 2); data_data_ok = (c == 2);
      data_rdata = $urandom;
      if (c == 2) load_req_m = 0;
      #1;
      if (c >= 3 && load_stall) stallAfter++;
      if (result_vld_w) vldSeen++;
      step();
    end
    flush_except = 0; data_addr_ok = 0; data_data_ok = 0;
    total++; if (stallAfter !== 0) begin bad++; $display("FAIL flushdata_stall got=%0d exp=0", stallAfter); end
    total++; if (vldSeen !== 0) begin bad++; $display("FAIL flushdata_vld got=%0d exp=0", vldSeen); end
  endtask

  task automatic test_timeout();
    int buCount; int buCycle; int drainStall; int stallAfter; int vldSeen;
    buCount = 0; buCycle = -1; drainStall = 0; stallAfter = 0; vldSeen = 0;
    load_req_m = 1; load_op_m = EXE_LW; addr_m = 32'h4000;
    for (int c = 0; c < 12; c++) begin
      data_addr_ok = (c == 1); data_data_ok = (c == 9); data_rdata = $urandom;
      if (c == 6) load_req_m = 0;
      #1;
      if (load_buserr) begin buCount++; buCycle = c; end
      if (c >= 6 && c <= 9 && load_stall) drainStall++;
      if (c >= 10 && load_stall) stallAfter++;
      if (result_vld_w) vldSeen++;
      step();
    end
    data_addr_ok = 0; data_data_ok = 0;
    total++; if (buCount !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", buCount); end
    total++; if (buCycle !== 5) begin bad++; $display("FAIL timeout_cycle got=%0d exp=5", buCycle); end
    total++; if (drainStall !== 4) begin bad++; $display("FAIL timeout_drain_stall got=%0d exp=4", drainStall); end
    total++; if (stallAfter !== 0) begin bad++; $display("FAIL timeout_idle_stall got=%0d exp=0", stallAfter); end
    total++; if (vldSeen !== 0) begin bad++; $display("FAIL timeout_vld got=%0d exp=0", vldSeen); end
  endtask

  task automatic test_reset_mid();
    int busy; int vldSeen;
    busy = 0; vldSeen = 0;
    load_req_m = 1; load_op_m = EXE_LW; addr_m = 32'h4400;
    for (int c = 0; c < 7; c++) begin
      data_addr_ok = (c == 1); data_data_ok = (c == 3) || (c == 4); data_rdata = $urandom;
      rst = (c == 2);
      if (c == 2) load_req_m = 0;
      #1;
      if (c >= 3 && (load_stall || data_req)) busy++;
      if (c >= 3 && result_vld_w) vldSeen++;
      step();
    end
    data_addr_ok = 0; data_data_ok = 0; rst = 0;
    total++; if (busy !== 0) begin bad++; $display("FAIL rstmid_busy got=%0d exp=0", busy); end
    total++; if (vldSeen !== 0) begin bad++; $display("FAIL rstmid_vld got=%0d exp=0", vldSeen); end
    total++; if (result_w !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", result_w); end
    lastResult = '0;
  endtask

  task automatic test_lwlr();
`ifdef LOAD_LWLR_EN
    int st; int vc; bit ast; bit rq; bit fin; logic [31:0] res;
    run_load(EXE_LWL, 32'h5001, 32'h1122_3344, 32'hAABB_CCDD, 1, 1, st, ast, vc, res, rq, fin);
    total++; if (res !== 32'hCCDD_3344) begin bad++; $display("FAIL lwl_result got=%h exp=ccdd3344", res); end
    total++; if (vc !== 1) begin bad++; $display("FAIL lwl_vld_cycles got=%0d exp=1", vc); end
    lastResult = res;
`else
    int busy; int vldSeen;
    busy = 0; vldSeen = 0;
    load_req_m = 1; load_op_m = EXE_LWL; addr_m = 32'h5001; rt_m = 32'h1122_3344;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) load_op_m = EXE_LWR;
      #1;
      if (data_req || load_stall || load_adel) busy++;
      if (result_vld_w) vldSeen++;
      step();
    end
    load_req_m = 0;
    step();
    total++; if (busy !== 0) begin bad++; $display("FAIL lwlr_disabled_activity got=%0d exp=0", busy); end
    total++; if (vldSeen !== 0) begin bad++; $display("FAIL lwlr_disabled_vld got=%0d exp=0", vldSeen); end
`endif
  endtask

  task automatic test_random();
    logic [5:0] op; logic [31:0] addr; logic [31:0] rt; logic [31:0] rd; logic [31:0] exp; logic [31:0] res;
    int aDly; int dDly; int st; int vc; bit ast; bit rq; bit fin; int busy;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(7) == 0) ? 6'($urandom_range(63)) : 6'(32 + $urandom_range(6));
      addr = $urandom; rt = $urandom; rd = $urandom;
      if ($urandom_range(1) == 1 && modelAdel(op, addr)) addr = addr & 32'hFFFF_FFFC;
      if (!modelIsLoad(op) || modelAdel(op, addr)) begin
        busy = 0;
        load_req_m = 1; load_op_m = op; addr_m = addr;
        #1;
        if (data_req || load_stall) busy++;
        total++; if (load_adel !== (modelIsLoad(op) && modelAdel(op, addr))) begin
          bad++; $display("FAIL rand_adel op=%h addr=%h got=%b", op, addr, load_adel);
        end
        step();
        load_req_m = 0;
        step();
        total++; if (busy !== 0) begin bad++; $display("FAIL rand_noissue op=%h addr=%h got=%0d exp=0", op, addr, busy); end
      end else begin
        aDly = $urandom_range(1, 3); dDly = $urandom_range(0, 3);
        exp = modelResult(op, addr, rd, rt);
        run_load(op, addr, rt, rd, aDly, dDly, st, ast, vc, res, rq, fin);
        total++; if (fin !== 1'b1) begin bad++; $display("FAIL rand_finish op=%h got=%b exp=1", op, fin); end
        total++; if (res !== exp) begin bad++; $display("FAIL rand_result op=%h addr=%h got=%h exp=%h", op, addr, res, exp); end
        total++; if (st !== aDly + dDly + 1) begin bad++; $display("FAIL rand_stall got=%0d exp=%0d", st, aDly + dDly + 1); end
        total++; if (vc !== 1 || rq !== 1'b0 || ast !== 1'b1) begin
          bad++; $display("FAIL rand_handshake vld=%0d reqdone=%b stable=%b exp=1/0/1", vc, rq, ast);
        end
        lastResult = exp;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_adel();
    test_lw_delayed();
    test_flush();
    test_flush_with_data();
    test_timeout();
    test_reset_mid();
    test_lwlr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
